// File: rtl/serial_port_pkg.sv
// Shared constants and state encodings for the memory-mapped serial port.
// Address map, register offsets, status bit positions and FSM encodings live here.
package serial_port_pkg;

   localparam logic [15:0] ROM_TOP = 16'h8000;
   localparam logic [15:0] IO_BASE = 16'hFF00;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;

   localparam int ST_TX_FULL   = 0;
   localparam int ST_TX_EMPTY  = 1;
   localparam int ST_RX_AVAIL  = 2;
   localparam int ST_OVERRUN   = 3;
   localparam int ST_FRAME_ERR = 4;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/serial_port_fifo_sync.sv
// Single-clock FIFO with combinational read port (dout shows the head entry).
// A push while full is accepted only if a pop happens on the same edge.
module fifo_sync #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/serial_port.sv
// Bus decode plus 8N1 serial port with a TX FIFO and a 1-byte RX holding register.
//
// TX state | meaning
// IDLE     | line high, waiting for FIFO data
// START    | driving start bit (0)
// DATA     | shifting 8 data bits, LSB first
// STOP     | driving stop bit (1); chains to START if FIFO has data
//
// RX state | meaning
// IDLE     | waiting for synchronized 1->0 on rxd
// START    | half-bit wait, then confirm start bit still low
// DATA     | sampling 8 bits at bit centres
// STOP     | sampling stop bit, then store / flag
module serial_port
   import serial_port_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = IO_BASE,
   parameter int          DIV       = 16,
   parameter int          TX_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] a,
   inout  wire  [7:0]  d,
   input  logic        oe,
   input  logic        we,
   output logic        rom_n_cs,
   output logic        ram_n_cs,
   output logic        txd,
   input  logic        rxd
);

   localparam logic [15:0] BIT_LAST  = 16'(DIV - 1);
   localparam logic [15:0] HALF_LAST = 16'(DIV/2 - 1);
   localparam int          CW        = $clog2(TX_DEPTH) + 1;

   logic       io_sel;
   logic [1:0] offset;
   logic [7:0] rd_data;
   logic [7:0] status;

   logic       oe_armed, we_armed;
   logic       rd_fire, wr_fire;
   logic       pop_rx, push_tx, clr_flags;

   logic [7:0]    fifo_dout;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          tx_pop;
   logic          tx_empty;

   tx_state_t  tx_state;
   logic [15:0] tx_cnt;
   logic [2:0]  tx_idx;
   logic [7:0]  tx_shift;

   rx_state_t  rx_state;
   logic [15:0] rx_cnt;
   logic [2:0]  rx_idx;
   logic [7:0]  rx_shift;
   logic        rx_s1, rx_s2, rx_prev;
   logic [7:0]  rx_data;
   logic        rx_avail, overrun, frame_err;

   // Window is assumed 4-byte aligned, so the low address bits are the offset.
   assign io_sel   = (a >= BASE_ADDR) && (a <= BASE_ADDR + 16'd3);
   assign offset   = a[1:0];
   assign rom_n_cs = !(a < ROM_TOP);
   assign ram_n_cs = !((a >= ROM_TOP) && (a < BASE_ADDR));

   assign tx_empty = (fifo_count == '0) && (tx_state == TX_IDLE);

   always_comb begin
      status               = 8'h00;
      status[ST_TX_FULL]   = fifo_full;
      status[ST_TX_EMPTY]  = tx_empty;
      status[ST_RX_AVAIL]  = rx_avail;
      status[ST_OVERRUN]   = overrun;
      status[ST_FRAME_ERR] = frame_err;
   end

   always_comb begin
      rd_data = 8'h00;
      case (offset)
         REG_DATA:   rd_data = rx_avail ? rx_data : 8'h00;
         REG_STATUS: rd_data = status;
         default:    rd_data = 8'h00;
      endcase
   end

   assign d = (!oe && io_sel) ? rd_data : 8'bz;

   // A strobe fires once: only on the first edge after it was seen high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         oe_armed <= 1'b1;
         we_armed <= 1'b1;
      end else begin
         oe_armed <= oe;
         we_armed <= we;
      end
   end

   assign rd_fire   = !oe && oe_armed;
   assign wr_fire   = !we && we_armed;
   assign pop_rx    = rd_fire && io_sel && (offset == REG_DATA);
   assign push_tx   = wr_fire && io_sel && (offset == REG_DATA);
   assign clr_flags = wr_fire && io_sel && (offset == REG_STATUS);

   fifo_sync #(
      .WIDTH (8),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_tx),
      .din   (d),
      .pop   (tx_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign tx_pop = !fifo_empty &&
                   ((tx_state == TX_IDLE) ||
                    ((tx_state == TX_STOP) && (tx_cnt == '0)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_shift <= '0;
         txd      <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (tx_pop) begin
                  tx_shift <= fifo_dout;
                  txd      <= 1'b0;
                  tx_cnt   <= BIT_LAST;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (tx_cnt == '0) begin
                  txd      <= tx_shift[0];
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  tx_idx   <= '0;
                  tx_cnt   <= BIT_LAST;
                  tx_state <= TX_DATA;
               end else begin
                  tx_cnt <= tx_cnt - 1'b1;
               end
            end
            TX_DATA: begin
               if (tx_cnt == '0) begin
                  tx_cnt <= BIT_LAST;
                  if (tx_idx == 3'd7) begin
                     txd      <= 1'b1;
                     tx_state <= TX_STOP;
                  end else begin
                     txd      <= tx_shift[0];
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     tx_idx   <= tx_idx + 1'b1;
                  end
               end else begin
                  tx_cnt <= tx_cnt - 1'b1;
               end
            end
            TX_STOP: begin
               if (tx_cnt == '0) begin
                  if (tx_pop) begin
                     tx_shift <= fifo_dout;
                     txd      <= 1'b0;
                     tx_cnt   <= BIT_LAST;
                     tx_state <= TX_START;
                  end else begin
                     tx_state <= TX_IDLE;
                  end
               end else begin
                  tx_cnt <= tx_cnt - 1'b1;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
         rx_prev   <= 1'b1;
         rx_state  <= RX_IDLE;
         rx_cnt    <= '0;
         rx_idx    <= '0;
         rx_shift  <= '0;
         rx_data   <= '0;
         rx_avail  <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_s1   <= rxd;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;

         if (pop_rx) rx_avail <= 1'b0;
         if (clr_flags) begin
            if (d[ST_OVERRUN])   overrun   <= 1'b0;
            if (d[ST_FRAME_ERR]) frame_err <= 1'b0;
         end

         // Later assignments below win, so a new byte beats a same-edge pop or clear.
         case (rx_state)
            RX_IDLE: begin
               if (rx_prev && !rx_s2) begin
                  rx_cnt   <= HALF_LAST;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (rx_cnt == '0) begin
                  if (rx_s2) begin
                     rx_state <= RX_IDLE;
                  end else begin
                     rx_idx   <= '0;
                     rx_cnt   <= BIT_LAST;
                     rx_state <= RX_DATA;
                  end
               end else begin
                  rx_cnt <= rx_cnt - 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == '0) begin
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  rx_cnt   <= BIT_LAST;
                  if (rx_idx == 3'd7) rx_state <= RX_STOP;
                  else                rx_idx   <= rx_idx + 1'b1;
               end else begin
                  rx_cnt <= rx_cnt - 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == '0) begin
                  rx_state <= RX_IDLE;
                  if (rx_s2) begin
                     if (!rx_avail || pop_rx) begin
                        rx_data  <= rx_shift;
                        rx_avail <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt - 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule
